// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC host-side sequencer.
package adc_pkg;

  localparam int unsigned RESOLUTION_DEF = 8;
  localparam int unsigned TIMEOUT_MARGIN = 4;

  typedef logic [RESOLUTION_DEF-1:0] result_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StHold
  } seq_state_t;

endpackage

// File: rtl/adc_result_fifo.sv
// Synchronous result FIFO; the head is a combinational read of registered storage.
module adc_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LevelW-1:0] level_q;
  logic [WIDTH-1:0]  last_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // When empty, keep presenting the most recently popped word.
  assign rdata_o = empty_o ? last_q : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      last_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
        last_q <= mem_q[rptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Host-side SAR ADC sequencer: start pulses, rdy-edge capture, result FIFO, sticky flags.
// Define ADC_SEQ_AVG_EN to push the truncated mean of every 4 captures instead of each one.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PERIOD_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          trig_i,
  input  logic [PERIOD_W-1:0]           period_i,
  input  logic                          clear_i,
  output logic                          adc_start_o,
  input  logic                          adc_rdy_i,
  input  logic [RESOLUTION-1:0]         adc_result_i,
  output logic [RESOLUTION-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic                          timeout_o
);

  localparam int unsigned TmoW = $clog2(RESOLUTION + TIMEOUT_MARGIN + 1);
  localparam int unsigned CntW = (PERIOD_W > TmoW) ? PERIOD_W : TmoW;
  // The edge that leaves START is the first of the RESOLUTION+TIMEOUT_MARGIN timeout ticks.
  localparam logic [CntW-1:0] TmoLoad = CntW'(RESOLUTION + TIMEOUT_MARGIN - 1);

  seq_state_t            state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  start_q;
  logic                  rdy_prev_q;
  logic                  overflow_q, timeout_q;
  logic                  rdy_rise, capture, timeout_evt;
  logic                  push, pop, full, empty, drop;
  logic [RESOLUTION-1:0] push_data;

  assign rdy_rise    = adc_rdy_i && !rdy_prev_q;
  assign capture     = (state_q == StWait) && rdy_rise;
  assign timeout_evt = (state_q == StWait) && !rdy_rise && (cnt_q == CntW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en_i || trig_i) begin
            state_q <= StStart;
            start_q <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StWait;
          cnt_q   <= TmoLoad;
        end
        StWait: begin
          if (capture) begin
            if (en_i) begin
              state_q <= StHold;
              cnt_q   <= CntW'(period_i);
            end else begin
              state_q <= StIdle;
            end
          end else if (timeout_evt) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (!en_i) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            state_q <= StStart;
            start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_start_o = start_q;

`ifdef ADC_SEQ_AVG_EN
  logic [RESOLUTION+1:0] acc_q, acc_sum;
  logic [1:0]            acc_cnt_q;
  logic                  en_q;

  assign acc_sum   = acc_q + {2'b00, adc_result_i};
  assign push      = capture && (acc_cnt_q == 2'd3);
  assign push_data = acc_sum[RESOLUTION+1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= en_i;
      if (timeout_evt || ((state_q == StIdle) && en_q && !en_i)) begin
        acc_q     <= '0;
        acc_cnt_q <= '0;
      end else if (capture) begin
        acc_q     <= push ? '0 : acc_sum;
        acc_cnt_q <= acc_cnt_q + 2'd1;
      end
    end
  end
`else
  assign push      = capture;
  assign push_data = adc_result_i;
`endif

  assign pop  = valid_o && ready_i;
  assign drop = push && full && !pop;

  adc_result_fifo #(
    .WIDTH (RESOLUTION),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  assign valid_o = !empty;

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_prev_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rdy_prev_q <= adc_rdy_i;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_i) begin
        overflow_q <= 1'b0;
      end
      if (timeout_evt) begin
        timeout_q <= 1'b1;
      end else if (clear_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer with a behavioural SAR ADC and result-queue model.
module tb_adc_sequencer;

  localparam int RES   = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 16;

  logic          clk;
  logic          rst_ni;
  logic          en, trig, clear, ready;
  logic [PW-1:0] period;
  logic          adc_start;
  logic          adc_rdy    = 1'b1;
  logic [7:0]    adc_result = 8'h00;
  logic [7:0]    data;
  logic          valid;
  logic [2:0]    level;
  logic          overflow, timeout;

  int n_vec = 0;
  int n_err = 0;

  adc_sequencer #(
    .RESOLUTION (RES),
    .FIFO_DEPTH (DEPTH),
    .PERIOD_W   (PW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en),
    .trig_i       (trig),
    .period_i     (period),
    .clear_i      (clear),
    .adc_start_o  (adc_start),
    .adc_rdy_i    (adc_rdy),
    .adc_result_i (adc_result),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .level_o      (level),
    .overflow_o   (overflow),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: rdy drops after the start cycle and rises RES+2 edges after it.
  logic       adc_dead  = 1'b0;
  logic [7:0] adc_vals [64];
  int         adc_wr    = 0;
  int         adc_rd    = 0;
  int         adc_edges = 0;
  logic       adc_busy  = 1'b0;

  always @(posedge clk) begin
    if (adc_start) begin
      adc_busy  <= 1'b1;
      adc_edges <= 1;
      adc_rdy   <= 1'b0;
    end else if (adc_busy) begin
      adc_edges <= adc_edges + 1;
      if (adc_edges == RES + 1) begin
        adc_busy <= 1'b0;
        if (!adc_dead) begin
          adc_rdy <= 1'b1;
          if (adc_rd < adc_wr) begin
            adc_result <= adc_vals[adc_rd];
            adc_rd     <= adc_rd + 1;
          end else begin
            adc_result <= 8'($urandom);
          end
        end
      end
    end
  end

  task automatic push_adc(input logic [7:0] v);
    adc_vals[adc_wr] = v;
    adc_wr = adc_wr + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the bench in the START cycle.
  task automatic trig_pulse(input string name);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check(name, adc_start, 1);
  endtask

  task automatic quiet(input int n, input string name);
    int c = 0;
    repeat (n) begin
      step();
      if (adc_start) c++;
    end
    check(name, c, 0);
  endtask

  typedef struct {
    logic [7:0] val;
    int         lvl;
    logic       ovf;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{val: 8'h11, lvl: 1, ovf: 1'b0};
    tbl[1] = '{val: 8'h22, lvl: 2, ovf: 1'b0};
    tbl[2] = '{val: 8'h33, lvl: 3, ovf: 1'b0};
    tbl[3] = '{val: 8'h44, lvl: 4, ovf: 1'b0};
    tbl[4] = '{val: 8'h55, lvl: 4, ovf: 1'b1};
    tbl[5] = '{val: 8'h66, lvl: 4, ovf: 1'b1};

    rst_ni = 1'b0; en = 1'b0; trig = 1'b0; clear = 1'b0; ready = 1'b0; period = '0;
    step();
    step();
    check("rst_start", adc_start, 0);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_data", data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", timeout, 0);
    rst_ni = 1'b1;
    step();

`ifndef ADC_SEQ_AVG_EN
    // One-shot capture latency.
    push_adc(8'hA5);
    trig_pulse("t1_start");
    for (int k = 1; k <= RES + 3; k++) begin
      step();
      if (k == 1) check("t1_start_width", adc_start, 0);
      if (k == RES + 2) check("t1_valid_early", valid, 0);
    end
    check("t1_valid", valid, 1);
    check("t1_data", data, 8'hA5);
    check("t1_level", level, 1);
    quiet(30, "t1_idle");
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t1_pop_valid", valid, 0);
    check("t1_pop_hold", data, 8'hA5);
    check("t1_pop_level", level, 0);

    // One-shot captures into a stalled FIFO: fill, overflow, then drain in order.
    for (int i = 0; i < 6; i++) begin
      push_adc(tbl[i].val);
      trig_pulse("tbl_start");
      repeat (RES + 3) step();
      check("tbl_level", level, tbl[i].lvl);
      check("tbl_ovf", overflow, tbl[i].ovf);
      check("tbl_head", data, tbl[0].val);
      repeat (3) step();
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tbl_drain", data, tbl[i].val);
      step();
    end
    ready = 1'b0;
    check("tbl_empty", valid, 0);
    check("tbl_empty_level", level, 0);
    check("tbl_ovf_sticky", overflow, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("tbl_ovf_clear", overflow, 0);

    // Conversion timeout.
    adc_dead = 1'b1;
    trig_pulse("tmo_start");
    for (int k = 1; k <= RES + 4; k++) begin
      step();
      if (k == RES + 3) check("tmo_early", timeout, 0);
    end
    check("tmo_set", timeout, 1);
    adc_dead = 1'b0;
    quiet(20, "tmo_idle");
    check("tmo_sticky", timeout, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("tmo_clear", timeout, 0);

    // Asynchronous reset mid-conversion; the stale rdy edge must not be captured.
    push_adc(8'h77);
    trig_pulse("rst_t_start");
    repeat (RES + 3) step();
    check("rst_pre_level", level, 1);
    push_adc(8'h88);
    trig_pulse("rst_t_start2");
    repeat (4) step();
    rst_ni = 1'b0;
    #1;
    check("rstw_valid", valid, 0);
    check("rstw_level", level, 0);
    check("rstw_data", data, 0);
    check("rstw_start", adc_start, 0);
    step();
    step();
    rst_ni = 1'b1;
    quiet(RES + 4, "rstw_idle");
    check("rstw_adc_rose", adc_rdy, 1);
    check("rstw_no_cap", valid, 0);
    check("rstw_no_cap_lvl", level, 0);

    // Periodic mode, then en_i dropped during the last conversion.
    begin
      int         st[$];
      logic [7:0] got[$];
      int         extra;
      push_adc(8'd1); push_adc(8'd2); push_adc(8'd3);
      period = 16'd5;
      ready  = 1'b1;
      en     = 1'b1;
      for (int t = 0; t < 200 && st.size() < 3; t++) begin
        step();
        if (adc_start) st.push_back(t);
        if (valid) got.push_back(data);
      end
      en = 1'b0;
      extra = 0;
      repeat (RES + 30) begin
        step();
        if (adc_start) extra++;
        if (valid) got.push_back(data);
      end
      check("per_starts", st.size(), 3);
      if (st.size() == 3) begin
        check("per_space1", st[1] - st[0], RES + 9);
        check("per_space2", st[2] - st[1], RES + 9);
      end
      check("per_extra", extra, 0);
      check("per_count", got.size(), 3);
      for (int i = 0; i < got.size() && i < 3; i++) check("per_data", got[i], i + 1);
      check("per_ovf", overflow, 0);
      ready = 1'b0;
    end

    // Randomised continuous run against a queue model of the FIFO and a spacing rule.
    begin
      logic [7:0] mq[$];
      logic       ovf_m, p_push, p_pop, p_clear, rdy_s, drop;
      logic [7:0] p_val, last_m;
      int         per_cur, prev_start;
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      step();
      ovf_m = 0; last_m = 0; p_push = 0; p_pop = 0; p_clear = 0; p_val = 0;
      rdy_s = adc_rdy;
      prev_start = -1;
      per_cur = $urandom_range(0, 6);
      period = PW'(per_cur);
      en = 1'b1;
      for (int t = 0; t < 1500; t++) begin
        step();
        if (p_pop) last_m = mq.pop_front();
        drop = 1'b0;
        if (p_push) begin
          if (mq.size() < DEPTH) mq.push_back(p_val);
          else drop = 1'b1;
        end
        if (p_clear) ovf_m = 1'b0;
        if (drop) ovf_m = 1'b1;
        check("rnd_valid", valid, mq.size() > 0);
        check("rnd_level", level, mq.size());
        check("rnd_ovf", overflow, ovf_m);
        check("rnd_data", data, (mq.size() > 0) ? mq[0] : last_m);
        check("rnd_tmo", timeout, 0);
        if (adc_start) begin
          if (prev_start >= 0) check("rnd_spacing", t - prev_start, RES + 4 + per_cur);
          prev_start = t;
          per_cur = $urandom_range(0, 6);
          period = PW'(per_cur);
        end
        ready   = ($urandom_range(0, 99) < 40);
        clear   = ($urandom_range(0, 99) < 3);
        p_clear = clear;
        p_pop   = (mq.size() > 0) && ready;
        p_push  = adc_rdy && !rdy_s;
        p_val   = adc_result;
        rdy_s   = adc_rdy;
      end
      en = 1'b0;
      ready = 1'b0;
      clear = 1'b0;
      check("rnd_started", prev_start >= 0, 1);
    end
`else
    // Averaging build: four captures yield one truncated-mean push.
    ready = 1'b0;
    push_adc(8'd10); push_adc(8'd11); push_adc(8'd12); push_adc(8'd13);
    for (int i = 0; i < 4; i++) begin
      trig_pulse("avg_start");
      repeat (RES + 3) step();
      check("avg_level", level, (i == 3) ? 1 : 0);
      repeat (3) step();
    end
    check("avg_valid", valid, 1);
    check("avg_data", data, 8'd11);
    check("avg_ovf", overflow, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
